// File: rtl/tpu_exec_engine.sv
// Command sequencer for MOVE / PRELOAD / COMPUTE bursts between SHM, INBUF, WBUF and the PE array.
// One command at a time: rows stream at 1/cycle, cmd_ready is low while a command is in flight.
module tpu_exec_engine #(
  parameter int LANES   = 4,
  parameter int ELEM_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255,
  localparam int ROW_W  = LANES * ELEM_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [1:0]          cmd_src,
  input  logic [1:0]          cmd_dst,
  input  logic [ADDR_W-1:0]   cmd_addr1,
  input  logic [ADDR_W-1:0]   cmd_addr2,
  input  logic [ADDR_W-1:0]   cmd_addr3,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [2:0]          mem_ren,
  output logic [2:0]          mem_wen,
  output logic [3*ADDR_W-1:0] mem_a,
  output logic [ROW_W-1:0]    mem_d,
  input  logic [3*ROW_W-1:0]  mem_q,
  output logic                pe_p_en,
  output logic                pe_c_en,
  output logic [ROW_W-1:0]    pe_weight,
  output logic [ROW_W-1:0]    pe_input,
  input  logic [ROW_W-1:0]    pe_result,
  input  logic                pe_finished,
  output logic                ele_en,
  output logic [ROW_W-1:0]    ele_in,
  input  logic [ROW_W-1:0]    ele_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_MOVE    = 2'd0;
  localparam logic [1:0] OP_PRELOAD = 2'd1;
  localparam logic [1:0] OP_COMPUTE = 2'd2;
  localparam logic [1:0] MEM_INBUF  = 2'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_DRAIN, S_WAIT_PE, S_ELE, S_WB, S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        op_q, src_q, dst_q;
  logic [ADDR_W-1:0] a1_q, a2_q, a3_q;
  logic [LEN_W-1:0]  len_q, cnt, wr_idx;
  logic              wr_vld;
  logic              pe_fin_q;
  logic [TW-1:0]     wcnt;
  logic              cmd_legal;
  logic [ADDR_W-1:0] rd_a1, rd_a2, wr_a2;
  logic [ROW_W-1:0]  q_src;
  int                src_i, dst_i;

  always_comb begin
    cmd_legal = (cmd_op != 2'd3) && (cmd_len != '0) &&
                (cmd_src != 2'd3) && (cmd_dst != 2'd3) &&
                !(cmd_op == OP_MOVE && cmd_src == cmd_dst) &&
                !(cmd_op == OP_PRELOAD && cmd_src == MEM_INBUF);
  end

  assign src_i = int'(src_q);
  assign dst_i = int'(dst_q);
  assign rd_a1 = a1_q + ADDR_W'(cnt);
  assign rd_a2 = a2_q + ADDR_W'(cnt);
  assign wr_a2 = a2_q + ADDR_W'(wr_idx);
  assign q_src = mem_q[src_i*ROW_W +: ROW_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      a1_q     <= '0;
      a2_q     <= '0;
      a3_q     <= '0;
      len_q    <= '0;
      cnt      <= '0;
      wr_idx   <= '0;
      wr_vld   <= 1'b0;
      pe_fin_q <= 1'b0;
      wcnt     <= '0;
    end else begin
      state  <= state_nx;
      wr_vld <= (state == S_STREAM);
      wr_idx <= cnt;
      if (state == S_IDLE && cmd_valid) begin
        op_q     <= cmd_op;
        src_q    <= cmd_src;
        dst_q    <= cmd_dst;
        a1_q     <= cmd_addr1;
        a2_q     <= cmd_addr2;
        a3_q     <= cmd_addr3;
        len_q    <= cmd_len;
        cnt      <= '0;
        pe_fin_q <= 1'b0;
        wcnt     <= '0;
      end
      if (state == S_STREAM)
        cnt <= cnt + LEN_W'(1);
      // An early completion from the PE array is remembered so WAIT_PE can be skipped.
      if (((state == S_STREAM && cnt != '0) || state == S_DRAIN) && pe_finished)
        pe_fin_q <= 1'b1;
      if (state == S_WAIT_PE)
        wcnt <= wcnt + TW'(1);
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    mem_ren   = '0;
    mem_wen   = '0;
    mem_a     = '0;
    mem_d     = '0;
    pe_p_en   = 1'b0;
    pe_c_en   = 1'b0;
    pe_weight = '0;
    pe_input  = '0;
    ele_en    = 1'b0;
    ele_in    = '0;

    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid)
          state_nx = cmd_legal ? S_STREAM : S_ERR;
      end
      S_STREAM: begin
        if (cnt == len_q - LEN_W'(1))
          state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (op_q == OP_COMPUTE) begin
          state_nx = (pe_fin_q || pe_finished) ? S_ELE : S_WAIT_PE;
        end else begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_WAIT_PE: begin
        if (pe_finished)
          state_nx = S_ELE;
        else if (wcnt == TW'(TIMEOUT - 1))
          state_nx = S_ERR;
      end
      S_ELE: begin
        ele_en   = 1'b1;
        ele_in   = pe_result;
        state_nx = S_WB;
      end
      S_WB: begin
        mem_wen[0]       = 1'b1;
        mem_a[ADDR_W-1:0] = a3_q;
        mem_d            = ele_out;
        done             = 1'b1;
        state_nx         = S_IDLE;
      end
      S_ERR: begin
        err      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (state == S_STREAM) begin
      if (op_q == OP_COMPUTE) begin
        mem_ren[1]                = 1'b1;
        mem_ren[2]                = 1'b1;
        mem_a[ADDR_W +: ADDR_W]   = rd_a1;
        mem_a[2*ADDR_W +: ADDR_W] = rd_a2;
      end else begin
        mem_ren[src_i]                = 1'b1;
        mem_a[src_i*ADDR_W +: ADDR_W] = rd_a1;
      end
    end

    // Read data lands one cycle after its read; wr_vld marks that cycle.
    if (wr_vld) begin
      case (op_q)
        OP_MOVE: begin
          mem_wen[dst_i]                = 1'b1;
          mem_a[dst_i*ADDR_W +: ADDR_W] = wr_a2;
          mem_d                         = q_src;
        end
        OP_PRELOAD: begin
          pe_p_en   = 1'b1;
          pe_weight = q_src;
        end
        default: begin
          pe_c_en   = 1'b1;
          pe_input  = mem_q[ROW_W +: ROW_W];
          pe_weight = mem_q[2*ROW_W +: ROW_W];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_exec_engine.sv
// Directed bench for tpu_exec_engine: behavioural memories and elementwise unit around the DUT,
// per-cycle checks of control strobes, addresses and data.
module tb_tpu_exec_engine;
  localparam int AW    = 6;
  localparam int LW    = 4;
  localparam int ROW_W = 128;
  localparam int TMO   = 255;
  localparam logic [ROW_W-1:0] PE_RES  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [ROW_W-1:0] ELE_OUT = 128'h0000_0001_0000_0001_0000_0001_0000_0001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0, cmd_src = '0, cmd_dst = '0;
  logic [AW-1:0] cmd_addr1 = '0, cmd_addr2 = '0, cmd_addr3 = '0;
  logic [LW-1:0] cmd_len = '0;
  logic busy, done, err;
  logic [2:0] mem_ren, mem_wen;
  logic [3*AW-1:0] mem_a;
  logic [ROW_W-1:0] mem_d;
  logic [3*ROW_W-1:0] mem_q;
  logic pe_p_en, pe_c_en;
  logic [ROW_W-1:0] pe_weight, pe_input;
  logic [ROW_W-1:0] pe_result = PE_RES;
  logic pe_finished = 1'b0;
  logic ele_en;
  logic [ROW_W-1:0] ele_in;
  logic [ROW_W-1:0] ele_out = '0;

  int vecs = 0;
  int miscompares = 0;

  tpu_exec_engine #(.LANES(4), .ELEM_W(32), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2), .cmd_addr3(cmd_addr3), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
    .pe_p_en(pe_p_en), .pe_c_en(pe_c_en), .pe_weight(pe_weight), .pe_input(pe_input),
    .pe_result(pe_result), .pe_finished(pe_finished),
    .ele_en(ele_en), .ele_in(ele_in), .ele_out(ele_out)
  );

  always #5 clk = ~clk;

  function automatic logic [ROW_W-1:0] row_pat(int m, int a);
    return {32'(m + 1), 32'(a), 32'(a * 3 + 7), 32'hCAFE0000 + 32'(m)};
  endfunction

  // Behavioural memories: 1-cycle read latency, write on the clock edge.
  logic [ROW_W-1:0] mem [3][64];
  logic [ROW_W-1:0] q [3];
  logic init_req = 1'b0;
  assign mem_q = {q[2], q[1], q[0]};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (init_req) begin
        for (int r = 0; r < 64; r++) mem[i][r] <= row_pat(i, r);
      end else begin
        if (mem_ren[i]) q[i] <= mem[i][mem_a[i*AW +: AW]];
        if (mem_wen[i]) mem[i][mem_a[i*AW +: AW]] <= mem_d;
      end
    end
    ele_out <= ele_en ? ELE_OUT : '0;
  end

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] ctl_exp(bit rdy, bit bsy, bit dn, bit er, bit p, bit c, bit e,
                                          logic [2:0] ren, logic [2:0] wen);
    return {rdy, bsy, dn, er, p, c, e, ren, wen};
  endfunction

  function automatic logic [12:0] ctl_now();
    return {cmd_ready, busy, done, err, pe_p_en, pe_c_en, ele_en, mem_ren, mem_wen};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic init_mems();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  task automatic issue(int op, int src, int dst, int a1, int a2, int a3, int len);
    cmd_op = 2'(op); cmd_src = 2'(src); cmd_dst = 2'(dst);
    cmd_addr1 = AW'(a1); cmd_addr2 = AW'(a2); cmd_addr3 = AW'(a3); cmd_len = LW'(len);
    cmd_valid = 1'b1;
    tick();
  endtask

  // MOVE (op 0) or PRELOAD (op 1); hold keeps cmd_valid asserted while busy.
  task automatic run_xfer(string tag, int op, int src, int dst, int a1, int a2, int len, bit hold);
    logic [2:0] ren, wen;
    bit rd, wr;
    init_mems();
    issue(op, src, dst, a1, a2, 0, len);
    if (!hold) cmd_valid = 1'b0;
    for (int c = 1; c <= len + 2; c++) begin
      rd  = (c <= len);
      wr  = (c >= 2 && c <= len + 1);
      ren = rd ? 3'(1 << src) : 3'b000;
      wen = (wr && op == 0) ? 3'(1 << dst) : 3'b000;
      check({tag, " ctl"}, ROW_W'(ctl_now()),
            ROW_W'(ctl_exp(c == len + 2, c <= len + 1, c == len + 1, 1'b0,
                           wr && op == 1, 1'b0, 1'b0, ren, wen)));
      if (rd) check({tag, " rd_addr"}, ROW_W'(mem_a[src*AW +: AW]), ROW_W'((a1 + c - 1) % 64));
      if (wr && op == 0) begin
        check({tag, " wr_addr"}, ROW_W'(mem_a[dst*AW +: AW]), ROW_W'((a2 + c - 2) % 64));
        check({tag, " wr_data"}, mem_d, row_pat(src, (a1 + c - 2) % 64));
      end
      if (wr && op == 1) begin
        check({tag, " pe_weight"}, pe_weight, row_pat(src, (a1 + c - 2) % 64));
        check({tag, " mem_d idle"}, mem_d, '0);
      end
      if (c == len + 1) cmd_valid = 1'b0;
      if (c < len + 2) tick();
    end
    if (op == 0)
      for (int i = 0; i < len; i++)
        check({tag, " dst row"}, mem[dst][(a2 + i) % 64], row_pat(src, (a1 + i) % 64));
  endtask

  // COMPUTE; fin = cycle of the pe_finished pulse, 0 = never.
  task automatic run_compute(string tag, int a1, int a2, int a3, int len, int fin);
    int ele_c, wb_c, err_c, end_c;
    bit rd, ce, el, wb, er;
    ele_c = ((fin <= len + 1) ? len + 1 : fin) + 1;
    wb_c  = ele_c + 1;
    err_c = len + 1 + TMO + 1;
    end_c = (fin != 0) ? wb_c : err_c;
    init_mems();
    issue(2, 0, 0, a1, a2, a3, len);
    cmd_valid = 1'b0;
    for (int c = 1; c <= end_c + 1; c++) begin
      rd = (c <= len);
      ce = (c >= 2 && c <= len + 1);
      el = (fin != 0 && c == ele_c);
      wb = (fin != 0 && c == wb_c);
      er = (fin == 0 && c == err_c);
      check({tag, " ctl"}, ROW_W'(ctl_now()),
            ROW_W'(ctl_exp(c == end_c + 1, c <= end_c, wb, er, 1'b0, ce, el,
                           rd ? 3'b110 : 3'b000, wb ? 3'b001 : 3'b000)));
      if (rd) begin
        check({tag, " in_addr"}, ROW_W'(mem_a[AW +: AW]), ROW_W'((a1 + c - 1) % 64));
        check({tag, " w_addr"}, ROW_W'(mem_a[2*AW +: AW]), ROW_W'((a2 + c - 1) % 64));
      end
      if (ce) begin
        check({tag, " pe_input"}, pe_input, row_pat(1, (a1 + c - 2) % 64));
        check({tag, " pe_weight"}, pe_weight, row_pat(2, (a2 + c - 2) % 64));
      end
      if (el) check({tag, " ele_in"}, ele_in, PE_RES);
      if (wb) begin
        check({tag, " wb_addr"}, ROW_W'(mem_a[AW-1:0]), ROW_W'(a3));
        check({tag, " wb_data"}, mem_d, ELE_OUT);
      end
      pe_finished = (fin != 0 && c == fin);
      if (c < end_c + 1) tick();
      pe_finished = 1'b0;
    end
    check({tag, " shm result"}, mem[0][a3], (fin != 0) ? ELE_OUT : row_pat(0, a3));
  endtask

  task automatic run_illegal(string tag, int op, int src, int dst, int len);
    issue(op, src, dst, 1, 2, 3, len);
    cmd_valid = 1'b0;
    check({tag, " ctl c1"}, ROW_W'(ctl_now()),
          ROW_W'(ctl_exp(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000)));
    check({tag, " addr c1"}, ROW_W'(mem_a), '0);
    tick();
    check({tag, " ctl c2"}, ROW_W'(ctl_now()),
          ROW_W'(ctl_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000)));
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset ctl", ROW_W'(ctl_now()),
          ROW_W'(ctl_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000)));
    reset = 1'b0;
    tick();
    check("idle ctl", ROW_W'(ctl_now()),
          ROW_W'(ctl_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000)));
    check("idle addr", ROW_W'(mem_a), '0);
    check("idle mem_d", mem_d, '0);
    check("idle pe_weight", pe_weight, '0);
    check("idle pe_input", pe_input, '0);
    check("idle ele_in", ele_in, '0);

    run_xfer("move shm->wbuf", 0, 0, 2, 5, 0, 3, 1'b1);
    run_xfer("move wrap", 0, 0, 1, 62, 10, 4, 1'b0);
    run_xfer("move wbuf->shm", 0, 2, 0, 60, 61, 5, 1'b0);
    run_xfer("preload shm", 1, 0, 0, 20, 0, 2, 1'b0);
    run_xfer("preload wbuf", 1, 2, 1, 63, 0, 3, 1'b0);

    run_compute("compute late", 3, 40, 17, 4, 8);
    run_compute("compute early", 61, 7, 33, 4, 3);
    run_compute("compute c2", 0, 0, 9, 2, 2);
    run_compute("compute timeout", 4, 5, 6, 1, 0);

    run_illegal("illegal src=dst", 0, 0, 0, 2);
    run_illegal("illegal op3", 3, 0, 1, 2);
    run_illegal("illegal len0", 0, 0, 2, 0);
    run_illegal("illegal preload inbuf", 1, 1, 0, 2);
    run_illegal("illegal src3", 0, 3, 1, 2);

    init_mems();
    issue(0, 0, 2, 0, 30, 0, 8);
    cmd_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset ctl", ROW_W'(ctl_now()),
          ROW_W'(ctl_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000)));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post reset quiet", ROW_W'(ctl_now()),
            ROW_W'(ctl_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000)));
    end
    run_xfer("move after reset", 0, 0, 2, 0, 30, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule

// File: doc/tpu_exec_engine.md
Name: tpu_exec_engine

Overview:
- Parametrised command sequencer that replaces the hard-wired per-state address/data muxing in the TPU top level.
- Accepts one decoded command at a time: MOVE, PRELOAD or COMPUTE.
- Streams multi-row bursts between shared memory, input buffer and weight buffer, and drives PE-array preload/compute.
- Writes elementwise results back to shared memory.
- Generalises the previous single-row, fixed-4-lane flow to LANES lanes, configurable element width, address depth and burst length.

Parameters:
- LANES, 4, elements per row.
- ELEM_W, 32, bits per element; ROW_W = LANES*ELEM_W.
- ADDR_W, 6, row address width of every memory.
- LEN_W, 4, burst length field width.
- TIMEOUT, 255, max cycles waiting for pe_finished.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  engine can accept a command
- cmd_op  in  2  0=MOVE, 1=PRELOAD, 2=COMPUTE, 3=illegal
- cmd_src  in  2  0=SHM, 1=INBUF, 2=WBUF, 3=illegal
- cmd_dst  in  2  same encoding as cmd_src
- cmd_addr1  in  ADDR_W  source / input base row
- cmd_addr2  in  ADDR_W  destination / weight base row
- cmd_addr3  in  ADDR_W  result row in SHM
- cmd_len  in  LEN_W  rows in burst; 0 is illegal
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- mem_ren  out  3  read enables, index 0=SHM, 1=INBUF, 2=WBUF
- mem_wen  out  3  write enables, same indexing
- mem_a  out  3*ADDR_W  addresses, slice i for memory i
- mem_d  out  ROW_W  write data, broadcast to all memories
- mem_q  in  3*ROW_W  read data, valid 1 cycle after ren
- pe_p_en  out  1  PE preload strobe
- pe_c_en  out  1  PE compute strobe
- pe_weight  out  ROW_W  PE weight row
- pe_input  out  ROW_W  PE input row
- pe_result  in  ROW_W  PE result row
- pe_finished  in  1  PE computation complete
- ele_en  out  1  elementwise enable
- ele_in  out  ROW_W  elementwise input
- ele_out  in  ROW_W  elementwise output, valid 1 cycle after ele_en

Behaviour:
- Reset: all outputs 0 except cmd_ready=1; state IDLE.
- Reset mid-command: the command is abandoned; no done or err is produced.
- States: IDLE, STREAM, DRAIN, WAIT_PE, ELE, WB.
- Handshake:
  - cmd_ready=1 only in IDLE; accept on cmd_valid&&cmd_ready at edge E0.
  - All command fields are latched at accept.
  - busy=1 from E0 until the cycle after done/err.
- Legality, checked at accept:
  - cmd_op=3, cmd_len=0, any src/dst=3 are illegal.
  - MOVE with src==dst is illegal.
  - PRELOAD with src=INBUF is illegal.
  - An illegal command gives err=1 in cycle 1, no memory access, then IDLE.
- Addresses are base+i modulo 2^ADDR_W; wrap-around is legal.
- MOVE:
  - STREAM cycles 1..len: mem_ren[src]=1, mem_a[src]=addr1+i.
  - Cycles 2..len+1: mem_wen[dst]=1, mem_a[dst]=addr2+i-1, mem_d=mem_q[src].
  - done in cycle len+1, together with the last write. Throughput is 1 row/cycle.
- PRELOAD:
  - Reads src rows as in MOVE.
  - Cycles 2..len+1: pe_p_en=1, pe_weight=mem_q[src].
  - done in cycle len+1.
- COMPUTE:
  - Cycles 1..len: reads INBUF at addr1+i and WBUF at addr2+i in parallel.
  - Cycles 2..len+1: pe_c_en=1, pe_input/pe_weight = the read data.
  - Then WAIT_PE until pe_finished.
  - A pe_finished seen any time after cycle 1 is latched; WAIT_PE then lasts 0 cycles.
  - ELE: ele_en=1, ele_in=pe_result for one cycle.
  - WB, next cycle: mem_wen[0]=1, mem_a[0]=addr3, mem_d=ele_out; done in this cycle.
  - If TIMEOUT cycles elapse in WAIT_PE: err pulse, no writeback, IDLE.
- Port rules:
  - A read and a write to the same memory never overlap, because MOVE forbids src==dst.
  - Undriven data outputs are 0 when their enable is low.
- cmd_valid while busy is ignored; cmd_ready=0 stalls the producer.

Test Plan:
- MOVE src=SHM dst=WBUF addr1=5 addr2=0 len=3, SHM rows 5..7 = A,B,C -> WBUF writes 0..2 = A,B,C in cycles 2..4; done in cycle 4; cmd_ready back high cycle 5.
- MOVE src=SHM dst=INBUF addr1=62 len=4 (ADDR_W=6) -> reads rows 62,63,0,1; writes to addr2..addr2+3 in order.
- PRELOAD src=SHM len=2 -> pe_p_en high exactly cycles 2..3 with correct rows; no mem_wen at any time.
- COMPUTE len=4, pe_finished at cycle 8, ele_out=0x...01 -> pe_c_en cycles 2..5; ele_en cycle 9; SHM write at addr3 in cycle 10 with done.
- COMPUTE with pe_finished never asserted, TIMEOUT=255 -> err pulse after 255 WAIT_PE cycles, no SHM write; illegal MOVE src=dst=SHM -> err in cycle 1, no ren.
- Reset asserted in cycle 3 of a len=8 MOVE -> next cycle all enables 0, cmd_ready=1, no done; a fresh command then completes normally.
